// File: rtl/whistle_pkg.sv
// whistle_pkg
//   Shared types and event table for the whistle sequencer.
//   Event index: 0 = serve, 1 = point, 2 = game-over.
package whistle_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BEEP = 2'd1,
        GAP  = 2'd2,
        REST = 2'd3
    } state_t;

    localparam int N_EV = 3;

    // Per-event pattern, packed so it can be indexed by the granted event.
    localparam logic [N_EV-1:0][1:0] BEEPS  = {2'd3,   2'd2,   2'd1};
    localparam logic [N_EV-1:0][8:0] BEEP_T = {9'd400, 9'd150, 9'd200};
    localparam logic [N_EV-1:0][8:0] GAP_T  = {9'd150, 9'd100, 9'd0};
    localparam logic [N_EV-1:0][1:0] PITCH  = {2'd2,   2'd1,   2'd0};

    // Silent guard after every event, in ticks.
    localparam logic [8:0] REST_T = 9'd50;

endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler
//   Divides clk down to a one-cycle tick every TICK_DIV cycles.
//   Ports:
//     clk    in  system clock
//     rst_n  in  async active-low reset
//     clr    in  restart the count from zero (no tick while asserted)
//     tick   out one-cycle pulse on the last cycle of each period
module tick_prescaler #(
    parameter int TICK_DIV = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    assign tick = (cnt == LAST) && !clr;

endmodule

// File: rtl/whistle_sched.sv
// whistle_sched
//   Queues one-shot whistle requests, grants them by fixed priority
//   (game-over > point > serve) and plays each event's beep/gap pattern.
//   Ports:
//     clk       in  system clock
//     rst_n     in  async active-low reset
//     req[2:0]  in  event requests, rising-edge detected
//     abort     in  cut the current event short (BEEP/GAP only)
//     tone_en   out tone generator running
//     tone_sel  out pitch select, updated only on grant
//     ack[2:0]  out one-cycle one-hot grant pulse
//     busy      out any state other than IDLE
module whistle_sched
    import whistle_pkg::*;
#(
    parameter int TICK_DIV = 256
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] req,
    input  logic       abort,
    output logic       tone_en,
    output logic [1:0] tone_sel,
    output logic [2:0] ack,
    output logic       busy
);

    state_t     state_q, state_d;
    logic [2:0] req_d;
    logic       armed;
    logic [2:0] rise;
    logic [2:0] pending;
    logic [1:0] cur_ev;
    logic [1:0] beeps_left;
    logic [8:0] tcnt;
    logic       tick;
    logic       pre_clr;
    logic       tcnt_clr;
    logic       beep_dec;
    logic [2:0] grant_vec;
    logic [1:0] grant_idx;
    logic       grant;

    // req_d clears on reset, so a level held through reset would look like a
    // fresh edge. 'armed' masks detection on the first cycle after release.
    assign rise = req & ~req_d & {3{armed}};

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pre_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        grant_vec = 3'b000;
        grant_idx = 2'd0;
        pre_clr   = 1'b0;
        tcnt_clr  = 1'b0;
        beep_dec  = 1'b0;
        case (state_q)
            IDLE: begin
                if (|pending) begin
                    if (pending[2])      grant_idx = 2'd2;
                    else if (pending[1]) grant_idx = 2'd1;
                    else                 grant_idx = 2'd0;
                    grant_vec = 3'b001 << grant_idx;
                    pre_clr   = 1'b1;
                    tcnt_clr  = 1'b1;
                    state_d   = BEEP;
                end
            end
            BEEP: begin
                if (abort) begin
                    // Restart the prescaler too so REST is a full REST_T.
                    pre_clr  = 1'b1;
                    tcnt_clr = 1'b1;
                    state_d  = REST;
                end else if (tick && tcnt == BEEP_T[cur_ev] - 9'd1) begin
                    tcnt_clr = 1'b1;
                    if (beeps_left > 2'd1) begin
                        beep_dec = 1'b1;
                        state_d  = GAP;
                    end else begin
                        state_d  = REST;
                    end
                end
            end
            GAP: begin
                if (abort) begin
                    pre_clr  = 1'b1;
                    tcnt_clr = 1'b1;
                    state_d  = REST;
                end else if (tick && tcnt == GAP_T[cur_ev] - 9'd1) begin
                    tcnt_clr = 1'b1;
                    state_d  = BEEP;
                end
            end
            REST: begin
                if (tick && tcnt == REST_T - 9'd1) begin
                    tcnt_clr = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign grant = |grant_vec;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d      <= 3'b000;
            armed      <= 1'b0;
            pending    <= 3'b000;
            ack        <= 3'b000;
            cur_ev     <= 2'd0;
            beeps_left <= 2'd0;
            tone_sel   <= 2'd0;
            tcnt       <= 9'd0;
        end else begin
            req_d   <= req;
            armed   <= 1'b1;
            // A rise in the grant cycle keeps the request queued.
            pending <= (pending & ~grant_vec) | rise;
            ack     <= grant_vec;
            if (grant) begin
                cur_ev     <= grant_idx;
                beeps_left <= BEEPS[grant_idx];
                tone_sel   <= PITCH[grant_idx];
            end else if (beep_dec) begin
                beeps_left <= beeps_left - 2'd1;
            end
            if (tcnt_clr)
                tcnt <= 9'd0;
            else if (tick)
                tcnt <= tcnt + 9'd1;
        end
    end

    assign tone_en = (state_q == BEEP);
    assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_whistle_sched.sv
// tb_whistle_sched
//   Directed bench for whistle_sched at TICK_DIV = 4.
module tb_whistle_sched;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] req;
    logic       abort;
    logic       tone_en;
    logic [1:0] tone_sel;
    logic [2:0] ack;
    logic       busy;

    int n_tests = 0;
    int n_fail  = 0;

    whistle_sched #(.TICK_DIV(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .abort    (abort),
        .tone_en  (tone_en),
        .tone_sel (tone_sel),
        .ack      (ack),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance one edge and sample 1 time unit later.
    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Length in cycles of the current run of tone_en (sel_busy=0) or busy (1).
    task automatic run_len(input bit sel_busy, output int n);
        logic lvl;
        lvl = sel_busy ? busy : tone_en;
        n = 0;
        while (((sel_busy ? busy : tone_en) == lvl) && n < 20000) begin
            n++;
            tick1();
        end
    endtask

    // Wait for the next grant; also count idle cycles seen on the way.
    task automatic wait_grant(output logic [2:0] a, output int idle);
        int n;
        idle = 0;
        n = 0;
        if (ack != 3'b000) tick1();
        while (ack == 3'b000 && n < 20000) begin
            if (!busy) idle++;
            tick1();
            n++;
        end
        a = ack;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 20000) begin
            tick1();
            n++;
        end
        chk("wait_idle_timeout", (n < 20000) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        int n, m, idle;
        logic [2:0] a;
        bit seen;

        // Reset with all requests held high.
        rst_n = 1'b0;
        req   = 3'b111;
        abort = 1'b0;
        repeat (3) tick1();
        chk("rst_tone_en",  32'(tone_en),  32'd0);
        chk("rst_tone_sel", 32'(tone_sel), 32'd0);
        chk("rst_ack",      32'(ack),      32'd0);
        chk("rst_busy",     32'(busy),     32'd0);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (10) begin
            tick1();
            if (busy || ack != 3'b000) seen = 1'b1;
        end
        chk("rst_held_no_grant", 32'(seen), 32'd0);
        req = 3'b000;
        repeat (2) tick1();

        // Single serve.
        req = 3'b001;
        tick1();
        chk("serve_ack_early", 32'(ack), 32'd0);
        tick1();
        req = 3'b000;
        chk("serve_ack",     32'(ack),      32'b001);
        chk("serve_tone_en", 32'(tone_en),  32'd1);
        chk("serve_sel",     32'(tone_sel), 32'd0);
        chk("serve_busy",    32'(busy),     32'd1);
        run_len(1'b0, n);
        chk("serve_beep_len", 32'(n), 32'd800);
        run_len(1'b1, m);
        chk("serve_busy_len", 32'(n + m), 32'd1000);

        // Point: two beeps with a gap.
        req = 3'b010;
        tick1();
        tick1();
        req = 3'b000;
        chk("point_ack", 32'(ack), 32'b010);
        run_len(1'b0, n);
        chk("point_beep1", 32'(n), 32'd600);
        chk("point_sel_gap", 32'(tone_sel), 32'd1);
        run_len(1'b0, n);
        chk("point_gap", 32'(n), 32'd400);
        run_len(1'b0, n);
        chk("point_beep2", 32'(n), 32'd600);
        run_len(1'b1, n);
        chk("point_rest", 32'(n), 32'd200);
        chk("point_sel_end", 32'(tone_sel), 32'd1);

        // Priority: serve and game-over together, point mid-event.
        req = 3'b101;
        tick1();
        req = 3'b000;
        tick1();
        chk("prio_ack1", 32'(ack), 32'b100);
        repeat (10) tick1();
        req = 3'b010;
        tick1();
        req = 3'b000;
        wait_grant(a, idle);
        chk("prio_ack2", 32'(a), 32'b010);
        chk("prio_idle2", 32'(idle), 32'd1);
        wait_grant(a, idle);
        chk("prio_ack3", 32'(a), 32'b001);
        chk("prio_idle3", 32'(idle), 32'd1);
        wait_idle();

        // Abort during the second game-over beep; serve queued before it.
        req = 3'b100;
        wait_grant(a, idle);
        req = 3'b000;
        chk("abort_ack", 32'(a), 32'b100);
        repeat (5) tick1();
        req = 3'b001;
        tick1();
        req = 3'b000;
        run_len(1'b0, n);
        run_len(1'b0, n);
        repeat (20) tick1();
        abort = 1'b1;
        tick1();
        abort = 1'b0;
        chk("abort_tone_off", 32'(tone_en), 32'd0);
        chk("abort_busy", 32'(busy), 32'd1);
        run_len(1'b1, n);
        chk("abort_rest", 32'(n), 32'd200);
        wait_grant(a, idle);
        chk("abort_queued_ack", 32'(a), 32'b001);
        chk("abort_idle", 32'(idle), 32'd1);
        wait_idle();

        // Async reset mid-beep with a request queued.
        req = 3'b001;
        wait_grant(a, idle);
        req = 3'b000;
        repeat (10) tick1();
        req = 3'b010;
        tick1();
        req = 3'b000;
        tick1();
        chk("areset_pre_tone", 32'(tone_en), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("areset_tone_off", 32'(tone_en), 32'd0);
        chk("areset_busy", 32'(busy), 32'd0);
        chk("areset_pending", 32'(dut.pending), 32'd0);
        tick1();
        tick1();
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick1();
            if (busy || ack != 3'b000) seen = 1'b1;
        end
        chk("areset_no_grant", 32'(seen), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/whistle_sched.md
# whistle_sched

Sequencer and arbiter for the whistle tone generator. Three game-logic requesters (serve, point, game-over) post one-shot whistle events. The block queues them, grants one at a time by fixed priority, and plays each event's beep/gap pattern by gating the tone generator's enable and selecting its pitch. It sits between game control and the whistle tone generator/PWM path.

## Interface
- `TICK_DIV`, default 256: clk cycles per timing tick (1 ms at 256 kHz); ≥ 2.
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  3  event requests; [0] serve, [1] point, [2] game-over; rising-edge detected.
- `abort`  in  1  synchronous; cuts the current event short.
- `tone_en`  out  1  1 = tone generator running (drives its reset as `~tone_en`).
- `tone_sel`  out  2  pitch/seed select for the tone generator.
- `ack`  out  3  one-cycle one-hot pulse when an event is granted.
- `busy`  out  1  1 in any state other than IDLE.

## Operation
- Registered `req_d`; `rise[i] = req[i] & ~req_d[i]`. A held level counts as one request.
- `pending[i]` is set by `rise[i]` and cleared on grant of `i`. Set wins over clear in the same cycle, so the new request stays queued. Repeated rises while pending coalesce into one request.
- FSM states IDLE, BEEP, GAP, REST.
  - IDLE: if any pending, grant highest index (2 > 1 > 0). On grant:
    - pulse `ack[i]`
    - load `beeps_left = BEEPS[i]`, `tone_sel = PITCH[i]`
    - clear the prescaler and tick counter
    - go to BEEP
  - BEEP: `tone_en` = 1. After `BEEP_T[i]` ticks: if `beeps_left > 1`, decrement and go to GAP; else go to REST.
  - GAP: after `GAP_T[i]` ticks, go to BEEP.
  - REST: silent guard. After `REST_T` ticks, go to IDLE.
- Event table:
  - serve: 1 beep of 200 ticks, gap 0, pitch 0
  - point: 2 beeps of 150 ticks, gap 100, pitch 1
  - game-over: 3 beeps of 400 ticks, gap 150, pitch 2
  - `REST_T` = 50
- `abort` in BEEP or GAP goes to REST at the next edge and clears the tick counter. Pending requests are kept. `abort` in IDLE or REST is ignored.
- Arithmetic: tick counter is 9 bits unsigned and compares against `duration - 1` on a tick. `beeps_left` is 2 bits. Prescaler width is `$clog2(TICK_DIV)`; it wraps at `TICK_DIV - 1` and emits one-cycle `tick`.
- `tone_sel` holds its last value after an event ends; it changes only on grant.

## Timing
- Reset (async, immediate): state IDLE; `tone_en`=0, `tone_sel`=0, `ack`=0, `busy`=0; `pending`, `req_d`, counters = 0.
- Latency: rise sampled at edge k sets `pending` at k. Grant, `ack`, `tone_en`=1 and `busy`=1 appear after edge k+1.
- BEEP lasts exactly `BEEP_T*TICK_DIV` cycles; GAP and REST are analogous. Total serve event: `(200+50)*TICK_DIV` cycles from grant to IDLE.
- Grant is evaluated only in IDLE. The earliest next grant is the cycle after REST→IDLE, so `busy` drops for exactly one cycle between back-to-back events.
- Simultaneous rises on several inputs: all are latched, and they are served in priority order.
- `rst_n` asserted mid-event: `tone_en` falls asynchronously and all queued requests are lost.

## Structure
- Package `whistle_pkg`:
  - state enum
  - `N_EV`=3
  - per-event constant arrays `BEEPS`, `BEEP_T`, `GAP_T`, `PITCH`
  - `REST_T`
- Sub-module `tick_prescaler` (`clk`, `rst_n`, `clr`, `tick`; parameter `TICK_DIV`).
- Top holds the edge detect, pending register, priority grant and FSM with counters.

## Test plan
Run with `TICK_DIV`=4.
- Reset: hold `rst_n`=0 with `req`=3'b111. Require all outputs 0. Release: no grant until a new rising edge on `req`.
- Single serve: pulse `req[0]`. Require:
  - `ack`=3'b001 two edges later
  - `tone_en` high for 800 cycles, `tone_sel`=0
  - `busy` low 1000 cycles after grant
- Point pattern: pulse `req[1]`. Require `tone_en` high 600 cycles, low 400, high 600, then 200 cycles of REST. `tone_sel`=1 throughout.
- Priority/queue: rise `req[0]` and `req[2]` in the same cycle, then rise `req[1]` mid-event. Require grant order 2, 1, 0 with one idle cycle between events.
- Abort: `abort` during the 2nd game-over beep. Require `tone_en`=0 next edge, REST for 200 cycles, then IDLE; a request queued before the abort is still granted.
- Async reset mid-beep: drop `rst_n` between edges. Require `tone_en`=0 before the next edge and `pending` cleared.
